// File: rtl/apu_pkg.sv
// Shared APU constants and helpers for the reversible-counter control path.
// Holds default widths, the sequencer top-value function and the direction encoding.
package apu_pkg;

  localparam int APU_TIMER_W = 11;
  localparam int APU_SEQ_W   = 5;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } seq_dir_e;

  // Highest sequencer value for a given width (31 for 5 bits).
  function automatic int seq_top(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/apu_reload_timer.sv
// Reloadable down-counting frequency timer; emits a registered 1-cycle step strobe
// each time the count expires on an enabled tick.
module apu_reload_timer #(
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_en,
  input  logic          period_load,
  input  logic [TW-1:0] period,
  output logic          step
);

  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] period_q, period_d;
  logic          step_q, step_d;

  // A load restarts the count and suppresses the strobe even if the timer had just expired.
  always_comb begin
    timer_d  = timer_q;
    period_d = period_q;
    step_d   = 1'b0;
    if (period_load) begin
      period_d = period;
      timer_d  = period;
    end else if (tick_en) begin
      if (timer_q == '0) begin
        timer_d = period_q;
        step_d  = 1'b1;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q  <= '0;
      period_q <= '0;
      step_q   <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      period_q <= period_d;
      step_q   <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/apu_rev_stepper.sv
// Timer-driven 5-bit up/down sequencer producing a 64-step symmetric waveform index
// together with the step/dec controls consumed by the reversible counter cells.
module apu_rev_stepper
  import apu_pkg::*;
#(
  parameter int TW = APU_TIMER_W,
  parameter int SW = APU_SEQ_W
) (
  input  logic          CLK,
  input  logic          n_RES,
  input  logic          ACLK_EN,
  input  logic          enable,
  input  logic [TW-1:0] period,
  input  logic          period_load,
  input  logic          seq_clear,
  output logic [SW-1:0] q,
  output logic          dec,
  output logic          step,
  output logic          at_bound
);

  localparam logic [SW-1:0] Q_TOP = SW'(seq_top(SW));

  logic          step_w;
  logic [SW-1:0] q_q, q_d;
  seq_dir_e      dir_q, dir_d;

  apu_reload_timer #(
    .TW (TW)
  ) u_timer (
    .clk         (CLK),
    .rst_n       (n_RES),
    .tick_en     (ACLK_EN),
    .period_load (period_load),
    .period      (period),
    .step        (step_w)
  );

  // Endpoints are held for one extra step while the direction flips, so q never wraps.
  always_comb begin
    q_d   = q_q;
    dir_d = dir_q;
    if (seq_clear) begin
      q_d   = '0;
      dir_d = DIR_UP;
    end else if (step_w && enable) begin
      if (dir_q == DIR_UP) begin
        if (q_q == Q_TOP) dir_d = DIR_DOWN;
        else              q_d   = q_q + SW'(1);
      end else begin
        if (q_q == '0) dir_d = DIR_UP;
        else           q_d   = q_q - SW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      q_q   <= '0;
      dir_q <= DIR_UP;
    end else begin
      q_q   <= q_d;
      dir_q <= dir_d;
    end
  end

  assign q        = q_q;
  assign dec      = (dir_q == DIR_DOWN);
  assign step     = step_w;
  assign at_bound = (q_q == '0) || (q_q == Q_TOP);

endmodule

// File: tb/tb_apu_rev_stepper.sv
// Directed bench for apu_rev_stepper: waveform sweep, freeze, async reset,
// half-rate ticking, load-vs-expiry and clear-vs-step cases.
module tb_apu_rev_stepper;

  logic        CLK;
  logic        n_RES;
  logic        ACLK_EN;
  logic        enable;
  logic [10:0] period;
  logic        period_load;
  logic        seq_clear;
  logic [4:0]  q;
  logic        dec;
  logic        step;
  logic        at_bound;

  int n_vec = 0;
  int n_err = 0;

  apu_rev_stepper dut (
    .CLK         (CLK),
    .n_RES       (n_RES),
    .ACLK_EN     (ACLK_EN),
    .enable      (enable),
    .period      (period),
    .period_load (period_load),
    .seq_clear   (seq_clear),
    .q           (q),
    .dec         (dec),
    .step        (step),
    .at_bound    (at_bound)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for the step strobe; n = edges taken until step was seen.
  task automatic wait_step(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < budget);
    chk("step_seen", {31'd0, step}, 32'd1);
  endtask

  // Expected waveform index after k sequencer advances from q=0, dec=0.
  function automatic int exp_q(input int k);
    int m;
    m = k % 64;
    return (m < 32) ? m : 63 - m;
  endfunction

  function automatic logic exp_dec(input int k);
    return (k % 64) >= 32;
  endfunction

  task automatic do_step(input int k, input int exp_ivl);
    int n;
    int e;
    wait_step(20, n);
    chk("step_ivl", n, exp_ivl);
    tick();
    e = exp_q(k);
    $display("step k=%0d q=%0d dec=%0d at_bound=%0d", k, q, dec, at_bound);
    chk("seq_q", {27'd0, q}, e);
    chk("seq_dec", {31'd0, dec}, {31'd0, exp_dec(k)});
    chk("seq_bound", {31'd0, at_bound}, {31'd0, (e == 0 || e == 31)});
    chk("step_width", {31'd0, step}, 32'd0);
  endtask

  initial begin
    int n;
    int guard;
    n_RES = 1'b1; ACLK_EN = 1'b0; enable = 1'b0;
    period = '0; period_load = 1'b0; seq_clear = 1'b0;
    #1 n_RES = 1'b0;
    #1;
    chk("rst_q", {27'd0, q}, 32'd0);
    chk("rst_dec", {31'd0, dec}, 32'd0);
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_bound", {31'd0, at_bound}, 32'd1);
    #10 n_RES = 1'b1;

    // Sweep with P=3: full 64-step cycle and onward to q=17 descending.
    period = 11'd3; period_load = 1'b1; ACLK_EN = 1'b1; enable = 1'b1;
    tick();
    period_load = 1'b0;
    chk("load_no_step", {31'd0, step}, 32'd0);
    for (int k = 1; k <= 110; k++) do_step(k, (k == 1) ? 4 : 3);

    // Freeze at q=17 descending for 10 steps, then resume downward.
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_step(20, n);
      chk("frz_ivl", n, 3);
      tick();
      chk("frz_q", {27'd0, q}, 32'd17);
      chk("frz_dec", {31'd0, dec}, 32'd1);
    end
    enable = 1'b1;
    for (int k = 111; k <= 118; k++) do_step(k, 3);

    // Asynchronous reset mid-descent at q=9.
    #1 n_RES = 1'b0;
    #1;
    chk("arst_q", {27'd0, q}, 32'd0);
    chk("arst_dec", {31'd0, dec}, 32'd0);
    chk("arst_step", {31'd0, step}, 32'd0);
    #1 n_RES = 1'b1;
    tick();
    chk("post_rst_step", {31'd0, step}, 32'd1);
    chk("post_rst_q0", {27'd0, q}, 32'd0);
    tick();
    chk("post_rst_q1", {27'd0, q}, 32'd1);
    chk("post_rst_step2", {31'd0, step}, 32'd1);
    tick();
    chk("post_rst_q2", {27'd0, q}, 32'd2);

    // Period 0 with half-rate enable: step on every other clock.
    for (int i = 0; i < 3; i++) begin
      ACLK_EN = 1'b0;
      tick();
      chk("half_step_lo", {31'd0, step}, 32'd0);
      ACLK_EN = 1'b1;
      tick();
      chk("half_step_hi", {31'd0, step}, 32'd1);
    end

    // Load while timer==0: load wins, next expiry after P+1 ticks.
    period = 11'd2; period_load = 1'b1;
    tick();
    period_load = 1'b0;
    chk("t3_load_wins", {31'd0, step}, 32'd0);
    wait_step(20, n);
    chk("t3_ivl1", n, 3);
    wait_step(20, n);
    chk("t3_ivl2", n, 3);

    // Clear coincident with the step that would flip direction at q=31.
    period = 11'd0; period_load = 1'b1;
    tick();
    period_load = 1'b0; seq_clear = 1'b1;
    tick();
    seq_clear = 1'b0;
    chk("clr_q", {27'd0, q}, 32'd0);
    chk("clr_dec", {31'd0, dec}, 32'd0);
    guard = 0;
    while (q !== 5'd31 && guard < 100) begin
      tick();
      guard++;
    end
    chk("t5_reach", {27'd0, q}, 32'd31);
    chk("t5_dec_pre", {31'd0, dec}, 32'd0);
    chk("t5_step_pre", {31'd0, step}, 32'd1);
    seq_clear = 1'b1;
    tick();
    seq_clear = 1'b0;
    chk("t5_q", {27'd0, q}, 32'd0);
    chk("t5_dec", {31'd0, dec}, 32'd0);
    chk("t5_bound", {31'd0, at_bound}, 32'd1);
    tick();
    chk("t5_q_up", {27'd0, q}, 32'd1);
    chk("t5_dec_up", {31'd0, dec}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
